// File: rtl/skew_feed_buffer.sv
// ============================================================================
//  Module   : skew_feed_buffer
//  Purpose  : N x DEPTH operand tile store streamed out with diagonal skew.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module skew_feed_buffer #(
    parameter int DATA_W = 16,
    parameter int N      = 4,
    parameter int DEPTH  = 4,
    parameter int LANE_W = 2,
    parameter int ADDR_W = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [LANE_W-1:0]     wr_lane,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic                  start,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  done,
    output logic                  out_valid,
    output logic [N*DATA_W-1:0]   out_data
);

    localparam int c_LAST = DEPTH + N - 2;
    localparam int c_T_W  = $clog2(DEPTH + N);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_DRAIN  = 2'd2
    } state_t;

    state_t                 r_state;
    logic [c_T_W-1:0]       r_t;
    logic [DATA_W-1:0]      r_store [N][DEPTH];
    logic [N*DATA_W-1:0]    w_beat;

    // Lane i shows word (t - i); outside the lane's window it is zero padding.
    always_comb begin
        w_beat = '0;
        for (int i = 0; i < N; i++) begin
            for (int d = 0; d < DEPTH; d++) begin
                if (r_t == c_T_W'(i + d)) begin
                    w_beat[i*DATA_W +: DATA_W] = r_store[i][d];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_t       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            for (int i = 0; i < N; i++) begin
                for (int d = 0; d < DEPTH; d++) begin
                    r_store[i][d] <= '0;
                end
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    // busy still high here means this is the done cycle.
                    if (busy) begin
                        busy <= 1'b0;
                        done <= 1'b0;
                    end else if (start) begin
                        r_state <= S_STREAM;
                        busy    <= 1'b1;
                        r_t     <= '0;
                    end else if (wr_en) begin
                        for (int i = 0; i < N; i++) begin
                            for (int d = 0; d < DEPTH; d++) begin
                                if (wr_lane == LANE_W'(i) && wr_addr == ADDR_W'(d)) begin
                                    r_store[i][d] <= wr_data;
                                end
                            end
                        end
                    end
                end
                S_STREAM: begin
                    if (!out_valid || out_ready) begin
                        out_data  <= w_beat;
                        out_valid <= 1'b1;
                        r_t       <= r_t + 1'b1;
                        if (r_t == c_T_W'(c_LAST)) begin
                            r_state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        done      <= 1'b1;
                        r_state   <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_skew_feed_buffer.sv
// ============================================================================
//  Module   : tb_skew_feed_buffer
//  Purpose  : Self-checking bench for skew_feed_buffer (N=4, DEPTH=3).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_skew_feed_buffer;

    localparam int DATA_W = 16;
    localparam int N      = 4;
    localparam int DEPTH  = 3;
    localparam int LANE_W = 2;
    localparam int ADDR_W = 2;
    localparam int OW     = N * DATA_W;
    localparam int BEATS  = DEPTH + N - 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              wr_en = 1'b0;
    logic [LANE_W-1:0] wr_lane = '0;
    logic [ADDR_W-1:0] wr_addr = '0;
    logic [DATA_W-1:0] wr_data = '0;
    logic              start = 1'b0;
    logic              out_ready = 1'b0;
    logic              busy;
    logic              done;
    logic              out_valid;
    logic [OW-1:0]     out_data;

    int n_cmp = 0;
    int n_err = 0;

    logic [DATA_W-1:0] mem [N][DEPTH];

    skew_feed_buffer #(
        .DATA_W(DATA_W), .N(N), .DEPTH(DEPTH), .LANE_W(LANE_W), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_lane(wr_lane),
        .wr_addr(wr_addr), .wr_data(wr_data), .start(start),
        .out_ready(out_ready), .busy(busy), .done(done),
        .out_valid(out_valid), .out_data(out_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [OW-1:0] obs, input logic [OW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference beat: lane i carries word (t-i) of lane i when in range, else 0.
    function automatic logic [OW-1:0] model_beat(input int t);
        logic [OW-1:0] b = '0;
        for (int i = 0; i < N; i++) begin
            if (t - i >= 0 && t - i < DEPTH) b[i*DATA_W +: DATA_W] = mem[i][t-i];
        end
        return b;
    endfunction

    task automatic clear_model();
        for (int i = 0; i < N; i++)
            for (int d = 0; d < DEPTH; d++) mem[i][d] = '0;
    endtask

    task automatic wr(input int lane, input int addr, input logic [DATA_W-1:0] data);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_lane = LANE_W'(lane);
        wr_addr = ADDR_W'(addr);
        wr_data = data;
        @(negedge clk);
        wr_en = 1'b0;
        if (lane < N && addr < DEPTH) mem[lane][addr] = data;
    endtask

    // mode: 0 ready high, 1 stall 3 cycles at beat 2, 2 random ready.
    // poke: pulse start and a BEEF write while streaming (both must be ignored).
    task automatic run_stream(input int mode, input bit poke);
        int  k = 0;
        int  cyc = 0;
        int  stall = 0;
        bit  got_done = 0;
        bit  prev_hold = 0;
        bit  rdy;
        logic [OW-1:0] prev = '0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", OW'(busy), OW'(1));
        chk("valid_before_e1", OW'(out_valid), OW'(0));
        while (!got_done && cyc < 200) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            wr_en = 1'b0;
            if (cyc == 1) chk("first_valid", OW'(out_valid), OW'(1));
            if (prev_hold) begin
                chk("hold_valid", OW'(out_valid), OW'(1));
                chk("hold_data", out_data, prev);
            end
            if (done) begin
                got_done = 1;
                chk("beat_count", OW'(k), OW'(BEATS));
                chk("busy_at_done", OW'(busy), OW'(1));
            end else begin
                if (mode == 0 && cyc > 1) chk("no_bubble", OW'(out_valid), OW'(1));
                if (mode == 0) rdy = 1'b1;
                else if (mode == 1) begin
                    rdy = !(k == 2 && stall < 3);
                    if (!rdy && out_valid) stall++;
                end else rdy = 1'($urandom_range(1, 0));
                out_ready = rdy;
                if (out_valid && rdy) begin
                    chk($sformatf("beat%0d", k), out_data, model_beat(k));
                    k++;
                end
                prev_hold = out_valid && !rdy;
                prev = out_data;
                if (poke && cyc == 3) start = 1'b1;
                if (poke && cyc == 4) begin
                    wr_en   = 1'b1;
                    wr_lane = '0;
                    wr_addr = '0;
                    wr_data = 16'hBEEF;
                end
            end
        end
        chk("done_seen", OW'(got_done), OW'(1));
        @(negedge clk);
        chk("done_one_cycle", OW'(done), OW'(0));
        chk("busy_drops", OW'(busy), OW'(0));
        out_ready = 1'b0;
    endtask

    initial begin
        int k;
        int cyc;
        clear_model();
        // Reset state
        #12;
        chk("rst_busy", OW'(busy), OW'(0));
        chk("rst_done", OW'(done), OW'(0));
        chk("rst_valid", OW'(out_valid), OW'(0));
        chk("rst_data", out_data, '0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed tile
        for (int i = 0; i < N; i++)
            for (int d = 0; d < DEPTH; d++) wr(i, d, DATA_W'(i*DEPTH + d + 1));
        run_stream(0, 0);
        run_stream(1, 0);
        run_stream(0, 1);
        chk("lane0_after_beef", OW'(mem[0][0]), OW'(1));
        run_stream(0, 0);

        // Out-of-range address write dropped
        wr(0, 3, 16'hBEEF);
        wr(2, 3, 16'h1234);
        run_stream(0, 0);

        // Random tiles with random backpressure
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < N; i++)
                for (int d = 0; d < DEPTH; d++) wr(i, d, DATA_W'($urandom));
            run_stream(2, 0);
            run_stream(r == 0 ? 1 : 2, 0);
        end

        // Reset mid-stream
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        out_ready = 1'b1;
        k = 0;
        cyc = 0;
        while (k < 3 && cyc < 50) begin
            @(negedge clk);
            cyc++;
            if (out_valid) k++;
        end
        chk("midrst_progress", OW'(k), OW'(3));
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", OW'(out_valid), OW'(0));
        chk("midrst_busy", OW'(busy), OW'(0));
        chk("midrst_data", out_data, '0);
        clear_model();
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b0;
        run_stream(0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
